// File: rtl/sra_multicycle.sv
// Multicycle 32-bit right shifter: five log-stages applied one per clock,
// arithmetic or logical fill, fixed five-cycle latency from accept to done.

module sra_stage #(
  parameter int W    = 32,
  parameter int DIST = 1
) (
  input  logic [W-1:0] din,
  input  logic         fill,
  output logic [W-1:0] dout
);
  // Shifting the complement in zeros and inverting back gives a ones-fill.
  assign dout = fill ? ~((~din) >> DIST) : (din >> DIST);
endmodule

module sra_multicycle (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [4:0]  shiftamt,
  input  logic        arith,
  output logic [31:0] result,
  output logic        ready,
  output logic        done
);
  localparam int W      = 32;
  localparam int STAGES = 5;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t                     state, state_nxt;
  logic [W-1:0]               work;
  logic [STAGES-1:0]          amt;
  logic                       fill;
  logic [2:0]                 stage;
  logic [STAGES-1:0][W-1:0]   cand;
  logic                       accept;
  logic                       last_stage;

  // One candidate per stage distance 2^k; the stage counter picks which applies.
  generate
    for (genvar k = 0; k < STAGES; k++) begin : g_stage
      sra_stage #(.W(W), .DIST(1 << k)) u_stage (
        .din  (work),
        .fill (fill),
        .dout (cand[k])
      );
    end
  endgenerate

  assign accept     = ready & start;
  assign last_stage = (stage == 3'(STAGES - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    ready     = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        ready = 1'b1;
        if (start) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_stage) state_nxt = DONE;
      end
      DONE: begin
        ready     = 1'b1;
        done      = 1'b1;
        state_nxt = start ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // arith only matters through the fill bit, so that is all that is kept.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      work   <= '0;
      amt    <= '0;
      fill   <= 1'b0;
      stage  <= '0;
      result <= '0;
    end else if (accept) begin
      work  <= A;
      amt   <= shiftamt;
      fill  <= arith & A[W-1];
      stage <= '0;
    end else if (state == SHIFT) begin
      if (amt[stage]) work <= cand[stage];
      if (last_stage) result <= amt[STAGES-1] ? cand[STAGES-1] : work;
      else            stage  <= stage + 3'd1;
    end
  end
endmodule

// File: tb/tb_sra_multicycle.sv
// Self-checking bench for sra_multicycle: directed corner vectors, mid-flight
// behaviour, asynchronous reset and a large randomized run against a shift model.

module tb_sra_multicycle;
  logic        clock = 1'b0;
  logic        reset_n;
  logic        start;
  logic [31:0] A;
  logic [4:0]  shiftamt;
  logic        arith;
  logic [31:0] result;
  logic        ready;
  logic        done;

  int total = 0;
  int bad   = 0;

  sra_multicycle dut (
    .clock    (clock),
    .reset_n  (reset_n),
    .start    (start),
    .A        (A),
    .shiftamt (shiftamt),
    .arith    (arith),
    .result   (result),
    .ready    (ready),
    .done     (done)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] ref_shift(input logic [31:0] a, input logic [4:0] s,
                                            input logic ar);
    logic signed [31:0] sa;
    logic [31:0]        r;
    sa = a;
    if (ar) r = sa >>> s;
    else    r = a >> s;
    return r;
  endfunction

  // Issues one operation, scrambles inputs after acceptance, and reports what it saw.
  task automatic run_op(input logic [31:0] a, input logic [4:0] s, input logic ar,
                        output int lat, output logic [31:0] res,
                        output int rdy_hi, output int unstable);
    logic [31:0] held;
    @(negedge clock);
    A = a; shiftamt = s; arith = ar; start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; A = $urandom; shiftamt = 5'($urandom); arith = 1'($urandom);
    held = result; lat = 0; rdy_hi = 0; unstable = 0;
    while (!done && lat < 20) begin
      if (ready) rdy_hi++;
      if (result !== held) unstable++;
      @(posedge clock); #1;
      lat++;
    end
    res = result;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; start = 1'b0; A = '0; shiftamt = '0; arith = 1'b0;
    #3;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
    @(posedge clock); @(posedge clock); #1;
    reset_n = 1'b1; start = 1'b1; A = 32'hF000_0000; shiftamt = 5'd8; arith = 1'b1;
    @(posedge clock); #1;
    total++; if (ready !== 1'b0) begin bad++; $display("FAIL first_edge_accept ready got=%b exp=0", ready); end
    start = 1'b0; A = '0;
    for (int i = 0; i < 10 && !done; i++) begin @(posedge clock); #1; end
    total++;
    if (done !== 1'b1 || result !== 32'hFFF0_0000) begin
      bad++; $display("FAIL first_op done=%b result=%h exp=fff00000", done, result);
    end
  endtask

  task automatic test_directed;
    logic [31:0] va [6] = '{32'h8000_0000, 32'h8000_0000, 32'h7FFF_FFFF,
                            32'h1234_5678, 32'h8000_0000, 32'h8000_0000};
    logic [4:0]  vs [6] = '{5'd4, 5'd4, 5'd31, 5'd0, 5'd31, 5'd31};
    logic        vr [6] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] ve [6] = '{32'hF800_0000, 32'h0800_0000, 32'h0000_0000,
                            32'h1234_5678, 32'hFFFF_FFFF, 32'h0000_0001};
    int lat, rh, un;
    logic [31:0] res;
    for (int i = 0; i < 6; i++) begin
      run_op(va[i], vs[i], vr[i], lat, res, rh, un);
      total++; if (res !== ve[i]) begin bad++; $display("FAIL directed_%0d result got=%h exp=%h", i, res, ve[i]); end
      total++; if (lat !== 5) begin bad++; $display("FAIL directed_%0d latency got=%0d exp=5", i, lat); end
      total++; if (rh !== 0) begin bad++; $display("FAIL directed_%0d ready_in_shift got=%0d exp=0", i, rh); end
    end
  endtask

  task automatic test_back_to_back;
    int c1, c2;
    @(negedge clock);
    A = 32'hC000_00F0; shiftamt = 5'd3; arith = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    A = 32'h0F0F_0F0F; shiftamt = 5'd9; arith = 1'b0;   // start stays high through SHIFT
    c1 = 0;
    while (!done && c1 < 20) begin @(posedge clock); #1; c1++; end
    total++; if (c1 !== 5) begin bad++; $display("FAIL b2b_first_latency got=%0d exp=5", c1); end
    total++;
    if (result !== ref_shift(32'hC000_00F0, 5'd3, 1'b1)) begin
      bad++; $display("FAIL b2b_first_result got=%h exp=%h", result, ref_shift(32'hC000_00F0, 5'd3, 1'b1));
    end
    @(posedge clock); #1;
    start = 1'b0; A = $urandom; shiftamt = 5'($urandom); arith = 1'($urandom);
    c2 = 1;
    while (!done && c2 < 20) begin @(posedge clock); #1; c2++; end
    total++; if (c2 !== 6) begin bad++; $display("FAIL b2b_gap got=%0d exp=6", c2); end
    total++;
    if (result !== ref_shift(32'h0F0F_0F0F, 5'd9, 1'b0)) begin
      bad++; $display("FAIL b2b_second_result got=%h exp=%h", result, ref_shift(32'h0F0F_0F0F, 5'd9, 1'b0));
    end
  endtask

  task automatic test_reset_midflight;
    int lat, rh, un, seen;
    logic [31:0] res;
    @(negedge clock);
    A = 32'h8765_4321; shiftamt = 5'd17; arith = 1'b1; start = 1'b1;
    @(posedge clock); #1; start = 1'b0;
    @(posedge clock); @(posedge clock); #2;
    reset_n = 1'b0;
    #1;
    total++; if (result !== 32'h0) begin bad++; $display("FAIL midreset_result got=%h exp=0", result); end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", ready); end
    total++; if (done !== 1'b0) begin bad++; $display("FAIL midreset_done got=%b exp=0", done); end
    @(posedge clock); #1; reset_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin @(posedge clock); #1; if (done) seen++; end
    total++; if (seen !== 0) begin bad++; $display("FAIL midreset_stray_done got=%0d exp=0", seen); end
    run_op(32'h8000_1234, 5'd5, 1'b1, lat, res, rh, un);
    total++;
    if (res !== ref_shift(32'h8000_1234, 5'd5, 1'b1) || lat !== 5) begin
      bad++; $display("FAIL post_reset_op result=%h lat=%0d exp=%h/5", res, lat, ref_shift(32'h8000_1234, 5'd5, 1'b1));
    end
  endtask

  task automatic test_random;
    int lat, rh, un, nfail;
    logic [31:0] a, res, exp;
    logic [4:0]  s;
    logic        ar;
    nfail = 0;
    for (int i = 0; i < 10000; i++) begin
      a = $urandom; s = 5'($urandom); ar = 1'($urandom);
      if (i % 4 == 0) a[31] = 1'b1;
      exp = ref_shift(a, s, ar);
      run_op(a, s, ar, lat, res, rh, un);
      total++;
      if (res !== exp || lat !== 5 || rh !== 0 || un !== 0) begin
        bad++;
        if (nfail < 10)
          $display("FAIL random_%0d a=%h s=%0d ar=%b got=%h exp=%h lat=%0d rdy=%0d unstable=%0d",
                   i, a, s, ar, res, exp, lat, rh, un);
        nfail++;
      end
    end
  endtask

  initial begin
    test_reset;
    test_directed;
    test_back_to_back;
    test_reset_midflight;
    test_random;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
